// File: rtl/spdif_subframe_encoder_if.sv
// Sample handshake bundle for the S/PDIF subframe encoder.
// The source drives the sample; the encoder answers with s_ready.
interface spdif_subframe_encoder_if #(
  parameter int SAMPLE_W = 24
);
  logic                s_valid;
  logic                s_ready;
  logic [SAMPLE_W-1:0] s_data;
  logic                s_v;
  logic                s_u;
  logic                s_c;

  modport master (
    output s_valid,
    output s_data,
    output s_v,
    output s_u,
    output s_c,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_v,
    input  s_u,
    input  s_c,
    output s_ready
  );
endinterface

// File: rtl/spdif_subframe_encoder.sv
// IEC 60958 subframe builder with biphase-mark line output.
// One clk1 cycle per half-cell; 64 cycles per subframe.
module spdif_subframe_encoder #(
  parameter  int SAMPLE_W     = 24,
  parameter  int NUM_CH       = 2,
  parameter  int BLOCK_FRAMES = 192,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk1,
  input  logic                 nrst,
  spdif_subframe_encoder_if.slave s,
  output logic                 dataDMC,
  output logic [CH_W-1:0]      ch_idx,
  output logic [7:0]           frame_idx,
  output logic                 block_start,
  output logic                 underrun
);

  localparam int AUD_PAD = 24 - SAMPLE_W;
  localparam int HOLD_W  = SAMPLE_W + 3;

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e state_q, state_d;

  logic [5:0]        hb_q, hb_d;
  logic              full_q, full_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [27:0]       sf_q, sf_d;
  logic [7:0]        pre_q, pre_d;
  logic              dmc_q, dmc_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [7:0]        frame_q, frame_d;
  logic              bs_q, bs_d;
  logic              ur_q, ur_d;

  logic              load;
  logic              accept;
  logic [CH_W-1:0]   ch_n;
  logic [7:0]        fr_n;
  logic [23:0]       aud;
  logic              bit_v;
  logic              bit_u;
  logic              bit_c;
  logic [26:0]       body;
  logic [7:0]        pat;
  logic [4:0]        slot;

  always_ff @(posedge clk1) begin
    if (nrst) begin
      state_q <= IDLE;
      hb_q    <= '0;
      full_q  <= 1'b0;
      hold_q  <= '0;
      sf_q    <= '0;
      pre_q   <= '0;
      dmc_q   <= 1'b0;
      ch_q    <= '0;
      frame_q <= '0;
      bs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hb_q    <= hb_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      sf_q    <= sf_d;
      pre_q   <= pre_d;
      dmc_q   <= dmc_d;
      ch_q    <= ch_d;
      frame_q <= frame_d;
      bs_q    <= bs_d;
      ur_q    <= ur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (full_q) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign accept = s.s_valid && !full_q;
  assign load   = (state_q == RUN) ? (hb_q == 6'd63) : full_q;

  // Counters only advance between subframes; the first one after IDLE is ch0/frame0.
  always_comb begin
    ch_n = ch_q;
    fr_n = frame_q;
    if (state_q == RUN) begin
      if (ch_q == CH_W'(NUM_CH - 1)) begin
        ch_n = '0;
        if (frame_q == 8'(BLOCK_FRAMES - 1)) fr_n = '0;
        else fr_n = frame_q + 8'd1;
      end else begin
        ch_n = ch_q + CH_W'(1);
      end
    end
  end

  always_comb begin
    aud   = '0;
    bit_v = 1'b1;
    bit_u = 1'b0;
    bit_c = 1'b0;
    if (full_q) begin
      aud   = 24'(hold_q[HOLD_W-1:3]) << AUD_PAD;
      bit_v = hold_q[2];
      bit_u = hold_q[1];
      bit_c = hold_q[0];
    end
    body = {bit_c, bit_u, bit_v, aud};
    pat  = PRE_W;
    unique case (1'b1)
      (ch_n == '0) && (fr_n == '0): pat = PRE_B;
      (ch_n == '0) && (fr_n != '0): pat = PRE_M;
      (ch_n != '0):                 pat = PRE_W;
      default:                      pat = PRE_W;
    endcase
  end

  always_comb begin
    hb_d    = hb_q;
    full_d  = full_q;
    hold_d  = hold_q;
    sf_d    = sf_q;
    pre_d   = pre_q;
    dmc_d   = dmc_q;
    ch_d    = ch_q;
    frame_d = frame_q;
    bs_d    = 1'b0;
    ur_d    = 1'b0;
    slot    = '0;

    if (accept) begin
      full_d = 1'b1;
      hold_d = {s.s_data, s.s_v, s.s_u, s.s_c};
    end else if (load) begin
      full_d = 1'b0;
    end

    if (load) begin
      ch_d    = ch_n;
      frame_d = fr_n;
      hb_d    = '0;
      sf_d    = {^body, body};
      // Preamble polarity follows the level left on the line.
      pre_d   = pat ^ {8{dmc_q}};
      dmc_d   = pre_d[7];
      bs_d    = (ch_n == '0) && (fr_n == '0);
      ur_d    = !full_q;
    end else if (state_q == RUN) begin
      hb_d = hb_q + 6'd1;
      slot = hb_d[5:1];
      if (hb_d < 6'd8) dmc_d = pre_q[~hb_d[2:0]];
      else if (!hb_d[0]) dmc_d = !dmc_q;
      else dmc_d = dmc_q ^ sf_q[5'(slot - 5'd4)];
    end
  end

  always_comb begin
    s.s_ready   = !full_q;
    dataDMC     = dmc_q;
    ch_idx      = ch_q;
    frame_idx   = frame_q;
    block_start = bs_q;
    underrun    = ur_q;
  end

endmodule

// File: tb/tb_spdif_subframe_encoder.sv
// Randomized bench for spdif_subframe_encoder against a
// subframe-level reference model of the line stream.
module tb_spdif_subframe_encoder;

  localparam int SW = 20;
  localparam int NC = 3;
  localparam int BF = 4;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  logic          clk1;
  logic          nrst;
  logic          dataDMC;
  logic [CW-1:0] ch_idx;
  logic [7:0]    frame_idx;
  logic          block_start;
  logic          underrun;

  spdif_subframe_encoder_if #(.SAMPLE_W(SW)) bus ();

  spdif_subframe_encoder #(
    .SAMPLE_W    (SW),
    .NUM_CH      (NC),
    .BLOCK_FRAMES(BF)
  ) u_dut (
    .clk1       (clk1),
    .nrst       (nrst),
    .s          (bus.slave),
    .dataDMC    (dataDMC),
    .ch_idx     (ch_idx),
    .frame_idx  (frame_idx),
    .block_start(block_start),
    .underrun   (underrun)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_run;
  int          m_hb;
  bit          m_full;
  logic [SW-1:0] m_d;
  bit          m_v, m_u, m_c;
  int          m_ch, m_frame;
  bit          m_bs, m_ur, m_line;
  bit          m_bits[64];
  int          n_acc;
  int          n_bs;
  int          n_ur;

  function automatic void build(input bit full, input logic [SW-1:0] d,
                                input bit v, input bit u, input bit c,
                                input int pt, input bit prior);
    logic [23:0] aud;
    logic [31:0] slots;
    logic [7:0]  p;
    bit          lvl;
    slots = '0;
    aud   = full ? (24'(d) << (24 - SW)) : 24'd0;
    for (int i = 0; i < 24; i++) slots[4 + i] = aud[i];
    slots[28] = full ? v : 1'b1;
    slots[29] = full ? u : 1'b0;
    slots[30] = full ? c : 1'b0;
    slots[31] = ($countones(slots[30:4]) % 2) == 1;
    case (pt)
      0:       p = 8'b1110_1000;
      1:       p = 8'b1110_0010;
      default: p = 8'b1110_0100;
    endcase
    for (int i = 0; i < 8; i++) m_bits[i] = p[7 - i] ^ prior;
    lvl = m_bits[7];
    for (int sl = 4; sl < 32; sl++) begin
      lvl = !lvl;
      m_bits[2 * sl] = lvl;
      if (slots[sl]) lvl = !lvl;
      m_bits[2 * sl + 1] = lvl;
    end
  endfunction

  task automatic model_step();
    bit acc, load;
    int pt;
    if (nrst) begin
      m_run = 0; m_hb = 0; m_full = 0;
      m_ch = 0; m_frame = 0;
      m_bs = 0; m_ur = 0; m_line = 0;
      return;
    end
    acc  = bus.s_valid && !m_full;
    load = m_run ? (m_hb == 63) : m_full;
    m_bs = 0;
    m_ur = 0;
    if (load) begin
      if (m_run) begin
        m_ch = m_ch + 1;
        if (m_ch == NC) begin
          m_ch = 0;
          m_frame = (m_frame + 1) % BF;
        end
      end
      pt = (m_ch != 0) ? 2 : ((m_frame == 0) ? 0 : 1);
      build(m_full, m_d, m_v, m_u, m_c, pt, m_line);
      m_bs = (m_ch == 0) && (m_frame == 0);
      m_ur = !m_full;
      m_hb = 0;
      m_run = 1;
      m_full = 0;
      if (m_bs) n_bs++;
      if (m_ur) n_ur++;
    end else if (m_run) begin
      m_hb++;
    end
    if (acc) begin
      m_full = 1;
      m_d = bus.s_data;
      m_v = bus.s_v;
      m_u = bus.s_u;
      m_c = bus.s_c;
      n_acc++;
    end
    m_line = m_run ? m_bits[m_hb] : 1'b0;
  endtask

  task automatic drive_sample(input int idx);
    logic [SW-1:0] d;
    d = '0;
    bus.s_v = 1'b0;
    bus.s_u = 1'b0;
    bus.s_c = 1'b0;
    if (idx == 1) begin
      d[SW-1] = 1'b1;
      d[0]    = 1'b1;
      bus.s_c = 1'b1;
    end else if (idx == 2) begin
      d = '1;
    end else if (idx > 2) begin
      d = SW'($urandom);
      bus.s_v = 1'($urandom);
      bus.s_u = 1'($urandom);
      bus.s_c = 1'($urandom);
    end
    bus.s_data = d;
  endtask

  bit did_rst;

  initial begin
    nrst = 1'b1;
    bus.s_valid = 1'b0;
    n_acc = 0;
    n_bs = 0;
    n_ur = 0;
    did_rst = 0;
    drive_sample(0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk1);
      model_step();
      #1;
      check("dataDMC", int'(dataDMC), int'(m_line));
      check("s_ready", int'(bus.s_ready), int'(!m_full));
      check("ch_idx", int'(ch_idx), m_ch);
      check("frame_idx", int'(frame_idx), m_frame);
      check("block_start", int'(block_start), int'(m_bs));
      check("underrun", int'(underrun), int'(m_ur));
      nrst = (cyc < 4);
      if (cyc >= 3000 && !did_rst && m_run && m_hb == 36) begin
        nrst = 1'b1;
        did_rst = 1;
      end
      if (cyc < 104) bus.s_valid = 1'b0;
      else if (cyc >= 2000 && cyc < 2300) bus.s_valid = 1'b0;
      else bus.s_valid = ($urandom_range(0, 3) != 0);
      drive_sample(n_acc);
    end
    check("reset_mid_subframe_hit", int'(did_rst), 1);
    check("block_starts_seen", int'(n_bs >= 3), 1);
    check("underruns_seen", int'(n_ur >= 3), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
